// File: rtl/mmio_io_responder_pkg.sv
// Shared register-map offsets and decode helper for the MMIO I/O responder.
package mmio_io_responder_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [7:0] IO_UART_CTRL = 8'h00;
    localparam logic [7:0] IO_UART_RX   = 8'h04;
    localparam logic [7:0] IO_UART_TX   = 8'h08;
    localparam logic [7:0] IO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] IO_INST_CNT  = 8'h14;
    localparam logic [7:0] IO_CNT_RST   = 8'h18;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_RX,
        REG_TX,
        REG_CYC,
        REG_INST,
        REG_CNT_RST
    } io_reg_e;

    function automatic io_reg_e decode_reg(input logic [7:0] off);
        case (off)
            IO_UART_CTRL: return REG_STATUS;
            IO_UART_RX:   return REG_RX;
            IO_UART_TX:   return REG_TX;
            IO_CYCLE_CNT: return REG_CYC;
            IO_INST_CNT:  return REG_INST;
            IO_CNT_RST:   return REG_CNT_RST;
            default:      return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// CPU load/store port into the IO window; master = core side, slave = responder.
interface mmio_io_responder_if;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_we;
    logic        io_re;
    logic [31:0] io_rdata;

    modport master (output io_addr, io_wdata, io_we, io_re, input io_rdata);
    modport slave  (input io_addr, io_wdata, io_we, io_re, output io_rdata);
endinterface

// File: rtl/mmio_io_responder_rx_fifo.sv
// Circular RX byte FIFO; only built when MMIO_RX_FIFO_EN is defined.
`ifdef MMIO_RX_FIFO_EN
module mmio_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule
`endif

// File: rtl/mmio_io_responder.sv
// MMIO responder: UART status/RX/TX and cycle/instret counters behind a 1-cycle read port.
// Define MMIO_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO; otherwise a one-byte holding register.
module mmio_io_responder
    import mmio_io_responder_pkg::*;
#(
    parameter logic [31:0] IO_BASE       = IO_BASE_DEFAULT,
    parameter int          RX_FIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    mmio_io_responder_if.slave   s_bus,
    input  logic                 i_inst_retire,
    input  logic [7:0]           i_uart_rx_data,
    input  logic                 i_uart_rx_valid,
    output logic                 o_uart_rx_ready,
    output logic [7:0]           o_uart_tx_data,
    output logic                 o_uart_tx_valid,
    input  logic                 i_uart_tx_ready
);
    io_reg_e     w_reg;
    logic        w_hit;
    logic        w_store;
    logic        w_tx_push;
    logic        w_cnt_clr;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [7:0]  w_rx_head;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_inst_cnt;
    logic [31:0] r_rdata;

    assign w_hit     = (s_bus.io_addr[31:8] == IO_BASE[31:8]);
    assign w_reg     = w_hit ? decode_reg(s_bus.io_addr[7:0]) : REG_NONE;
    assign w_store   = |s_bus.io_we;
    // A store while a byte is still pending is dropped; software polls tx_ready first.
    assign w_tx_push = w_store && (w_reg == REG_TX) && !r_tx_valid;
    assign w_cnt_clr = w_store && (w_reg == REG_CNT_RST);
    assign w_rx_push = i_uart_rx_valid && !w_rx_full;
    assign w_rx_pop  = s_bus.io_re && (w_reg == REG_RX) && !w_rx_empty;
    assign w_unused  = ^s_bus.io_wdata[31:8];

    assign o_uart_rx_ready = !w_rx_full;
    assign o_uart_tx_valid = r_tx_valid;
    assign o_uart_tx_data  = r_tx_data;
    assign s_bus.io_rdata  = r_rdata;

`ifdef MMIO_RX_FIFO_EN
    mmio_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_rx_push),
        .i_data  (i_uart_rx_data),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );
`else
    localparam int unused_rx_depth = RX_FIFO_DEPTH;
    logic       r_rx_full;
    logic [7:0] r_rx_byte;

    // Push and pop are exclusive here: push needs empty, pop needs full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_full <= 1'b0;
            r_rx_byte <= 8'h00;
        end else if (w_rx_pop) begin
            r_rx_full <= 1'b0;
        end else if (w_rx_push) begin
            r_rx_full <= 1'b1;
            r_rx_byte <= i_uart_rx_data;
        end
    end

    assign w_rx_full  = r_rx_full;
    assign w_rx_empty = !r_rx_full;
    assign w_rx_head  = r_rx_byte;
`endif

    // Read mux sees pre-edge state, so a same-cycle store does not affect the returned value.
    always_comb begin
        w_rdata = 32'h0;
        case (w_reg)
            REG_STATUS: w_rdata = {30'h0, !w_rx_empty, !r_tx_valid};
            REG_RX:     w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            REG_CYC:    w_rdata = r_cyc_cnt;
            REG_INST:   w_rdata = r_inst_cnt;
            default:    w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= 32'h0;
        end else if (s_bus.io_re) begin
            r_rdata <= w_rdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (r_tx_valid && i_uart_tx_ready) begin
            r_tx_valid <= 1'b0;
        end else if (w_tx_push) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= s_bus.io_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc_cnt  <= 32'h0;
            r_inst_cnt <= 32'h0;
        end else if (w_cnt_clr) begin
            r_cyc_cnt  <= 32'h0;
            r_inst_cnt <= 32'h0;
        end else begin
            r_cyc_cnt  <= r_cyc_cnt + 32'h1;
            r_inst_cnt <= r_inst_cnt + {31'h0, i_inst_retire};
        end
    end
endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder: register-map table plus TX/RX/counter/reset sequences.
module tb_mmio_io_responder;
    import mmio_io_responder_pkg::*;

`ifdef MMIO_RX_FIFO_EN
    localparam int RXCAP = 8;
`else
    localparam int RXCAP = 1;
`endif
    localparam logic [31:0] B = 32'h8000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inst_retire = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;

    mmio_io_responder_if bus ();

    mmio_io_responder #(.IO_BASE(B), .RX_FIFO_DEPTH(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .s_bus           (bus),
        .i_inst_retire   (inst_retire),
        .i_uart_rx_data  (rx_data),
        .i_uart_rx_valid (rx_valid),
        .o_uart_rx_ready (rx_ready),
        .o_uart_tx_data  (tx_data),
        .o_uart_tx_valid (tx_valid),
        .i_uart_tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        re;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [3:0] w,
                                input logic [31:0] d, input logic r, input logic c,
                                input logic [31:0] e);
        vec_t v;
        v.name = n; v.addr = a; v.we = w; v.wdata = d; v.re = r; v.chk = c; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_set(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           input logic r);
        bus.io_addr = a; bus.io_we = w; bus.io_wdata = d; bus.io_re = r;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_set(a, 4'h0, 32'h0, 1'b1);
        tick();
        bus.io_re = 1'b0;
        check(name, bus.io_rdata, exp);
    endtask

    initial begin
        bus_set(32'h0, 4'h0, 32'h0, 1'b0);
        tbl[0]  = mk("tbl_status",      B + 32'h00, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1);
        tbl[1]  = mk("tbl_rx_empty",    B + 32'h04, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[2]  = mk("tbl_rd_tx_wo",    B + 32'h08, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[3]  = mk("tbl_rd_cnt_rst",  B + 32'h18, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[4]  = mk("tbl_unmapped_0c", B + 32'h0C, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[5]  = mk("tbl_unmapped_fc", B + 32'hFC, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[6]  = mk("tbl_outside_hi",  32'h9000_0010, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[7]  = mk("tbl_status2",     B + 32'h00, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1);
        tbl[8]  = mk("tbl_outside_lo",  32'h7FFF_FF10, 4'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        tbl[9]  = mk("tbl_st_status",   B + 32'h00, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        tbl[10] = mk("tbl_st_outside",  32'h8000_0108, 4'hF, 32'h0000_0099, 1'b1, 1'b1, 32'h0);
        tbl[11] = mk("tbl_status3",     B + 32'h00, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1);
        tbl[12] = mk("tbl_hold",        B + 32'h10, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", bus.io_rdata, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            bus_set(tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].re);
            tick();
            if (tbl[i].chk) check(tbl[i].name, bus.io_rdata, tbl[i].exp);
        end
        bus_set(32'h0, 4'h0, 32'h0, 1'b0);
        check("tbl_no_tx", {31'h0, tx_valid}, 32'h0);

        // TX: push, hold under backpressure, dropped second store, handshake
        bus_set(B + 32'h08, 4'b1000, 32'h0000_0041, 1'b0);
        tick();
        bus.io_we = 4'h0;
        check("tx_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_data", {24'h0, tx_data}, 32'h41);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) bus_set(B + 32'h08, 4'hF, 32'h0000_0042, 1'b0);
            tick();
            bus.io_we = 4'h0;
            check("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
            check("tx_hold_data", {24'h0, tx_data}, 32'h41);
        end
        rd("status_tx_busy", B, 32'h0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_drop_after_hs", {31'h0, tx_valid}, 32'h0);
        rd("status_tx_idle", B, 32'h1);

        // Load and store in one cycle on the TX offset
        bus_set(B + 32'h08, 4'hF, 32'h0000_005A, 1'b1);
        tick();
        bus_set(32'h0, 4'h0, 32'h0, 1'b0);
        check("rewe_rdata", bus.io_rdata, 32'h0);
        check("rewe_tx_data", {23'h0, tx_valid, tx_data}, 32'h15A);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // RX single byte
        rx_data = 8'h55; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("rx_ready_after1", {31'h0, rx_ready}, (RXCAP > 1) ? 32'h1 : 32'h0);
        rd("rx_status", B, 32'h3);
        rd("rx_pop", B + 32'h04, 32'h55);
        rd("rx_status_after", B, 32'h1);
        rd("rx_pop_empty", B + 32'h04, 32'h0);

        // Fill beyond capacity, then drain
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h10 + 8'(i); rx_valid = 1'b1;
            tick();
            check("fill_ready", {31'h0, rx_ready}, (i + 1 < RXCAP) ? 32'h1 : 32'h0);
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 9; i++)
            rd("drain", B + 32'h04, (i < RXCAP) ? 32'h10 + 32'(i) : 32'h0);
        rd("drain_status", B, 32'h1);

        // Push and pop in the same cycle
        rx_data = 8'h60; rx_valid = 1'b1;
        tick();
`ifdef MMIO_RX_FIFO_EN
        rx_data = 8'h61;
        tick();
`endif
        rx_data = 8'h62;
        bus_set(B + 32'h04, 4'h0, 32'h0, 1'b1);
        tick();
        rx_valid = 1'b0; bus.io_re = 1'b0;
        check("pp_head", bus.io_rdata, 32'h60);
`ifdef MMIO_RX_FIFO_EN
        rd("pp_second", B + 32'h04, 32'h61);
        rd("pp_third", B + 32'h04, 32'h62);
`endif
        rd("pp_empty", B + 32'h04, 32'h0);

        // Counters: clear wins over retire, then 100 cycles with 40 retires
        bus_set(B + 32'h18, 4'hF, 32'h0, 1'b0);
        inst_retire = 1'b1;
        tick();
        bus.io_we = 4'h0;
        for (int i = 0; i < 100; i++) begin
            inst_retire = ((i % 5) < 2);
            tick();
        end
        inst_retire = 1'b0;
        rd("cyc_100", B + 32'h10, 32'd100);
        rd("inst_40", B + 32'h14, 32'd40);
        rd("cyc_102", B + 32'h10, 32'd102);
        bus_set(B + 32'h18, 4'h1, 32'h0, 1'b0);
        tick();
        bus.io_we = 4'h0;
        rd("cyc_clr", B + 32'h10, 32'd0);
        rd("inst_clr", B + 32'h14, 32'd0);
        rd("cyc_run", B + 32'h10, 32'd2);

        // Wrap of cycle counter
        force dut.r_cyc_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cyc_cnt;
        rd("cyc_max", B + 32'h10, 32'hFFFF_FFFF);
        rd("cyc_wrap", B + 32'h10, 32'h0);

        // Reset with TX pending and RX full
        for (int i = 0; i < RXCAP; i++) begin
            rx_data = 8'hA0 + 8'(i); rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        bus_set(B + 32'h08, 4'hF, 32'h0000_0077, 1'b0);
        tick();
        bus.io_we = 4'h0;
        check("pre_rst_full", {30'h0, rx_ready, tx_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        rd("post_rst_cyc", B + 32'h10, 32'h0);
        rd("post_rst_inst", B + 32'h14, 32'h0);
        rd("post_rst_rx", B + 32'h04, 32'h0);
        check("post_rst_tx_data", {23'h0, tx_valid, tx_data}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
